// File: rtl/arith_pkg.sv
// arith_pkg: shared constants and parameter checks for the arithmetic datapath.
package arith_pkg;

  localparam int ARITH_DEFAULT_WIDTH  = 128;
  localparam int ARITH_DEFAULT_STAGES = 8;

  // A width/stage pair is usable when the operand splits into equal, non-empty chunks.
  function automatic bit widthStagesOk(input int width, input int stages);
    return (stages >= 1) && (stages <= width) && ((width % stages) == 0);
  endfunction

endpackage

// File: rtl/pipe_adder_stage.sv
// pipe_adder_stage: one CHUNK-bit slice of the pipelined adder. A ripple of
// full-adder cells feeds a register holding the partial sum chunk, the carry
// handed to the next slice, the signed-overflow bit and the slice valid bit.
module pipe_adder_stage
  import arith_pkg::*;
#(
  parameter int CHUNK = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en_i,
  input  logic             valid_i,
  input  logic [CHUNK-1:0] a_i,
  input  logic [CHUNK-1:0] b_i,
  input  logic             carry_i,
  output logic             valid_o,
  output logic [CHUNK-1:0] sum_o,
  output logic             carry_o,
  output logic             ovf_o
);

  logic [CHUNK:0]   rippleC;
  logic [CHUNK-1:0] sum_d;
  logic [CHUNK-1:0] sum_q;
  logic             carry_d;
  logic             carry_q;
  logic             ovf_d;
  logic             ovf_q;
  logic             valid_q;

  // Ripple the chunk LSB first; overflow compares the carries into and out of the top cell.
  always_comb begin
    rippleC    = '0;
    sum_d      = '0;
    rippleC[0] = carry_i;
    for (int k = 0; k < CHUNK; k++) begin
      sum_d[k]       = a_i[k] ^ b_i[k] ^ rippleC[k];
      rippleC[k + 1] = (a_i[k] & b_i[k]) | (rippleC[k] & (a_i[k] ^ b_i[k]));
    end
    carry_d = rippleC[CHUNK];
    ovf_d   = rippleC[CHUNK] ^ rippleC[CHUNK - 1];
  end

  // Slice register: cleared by reset, otherwise frozen unless the whole pipe advances.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else if (en_i) begin
      valid_q <= valid_i;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      ovf_q   <= ovf_d;
    end
  end

  assign valid_o = valid_q;
  assign sum_o   = sum_q;
  assign carry_o = carry_q;
  assign ovf_o   = ovf_q;

endmodule

// File: rtl/pipe_adder.sv
// pipe_adder: WIDTH-bit add/subtract unit split into STAGES chunk slices with a
// registered carry between slices, one result per cycle and a valid/ready
// handshake. All slices advance together; a stalled consumer freezes the pipe.
module pipe_adder
  import arith_pkg::*;
#(
  parameter int WIDTH  = ARITH_DEFAULT_WIDTH,
  parameter int STAGES = ARITH_DEFAULT_STAGES
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             cout,
  output logic             ovf
);

  localparam int CHUNK = WIDTH / STAGES;

  if (!widthStagesOk(WIDTH, STAGES)) begin : gBadParams
    $error("pipe_adder: WIDTH must be a non-zero multiple of STAGES");
  end

  logic             adv;
  logic             accept;
  logic [WIDTH-1:0] bEff;
  logic             c0;

  // Skew registers: operands waiting for later slices and the sum chunks already finished.
  logic [WIDTH-1:0] opA_q    [STAGES];
  logic [WIDTH-1:0] opB_q    [STAGES];
  logic [WIDTH-1:0] sumLow_q [STAGES];
  logic [WIDTH-1:0] opA_d    [STAGES];
  logic [WIDTH-1:0] opB_d    [STAGES];
  logic [WIDTH-1:0] sumLow_d [STAGES];
  logic [WIDTH-1:0] sumAsm   [STAGES];

  logic [CHUNK-1:0] aChunk   [STAGES];
  logic [CHUNK-1:0] bChunk   [STAGES];
  logic [CHUNK-1:0] stageSum [STAGES];
  logic             stageOvf [STAGES];
  logic [STAGES-1:0] stageValidIn;
  logic [STAGES-1:0] stageCarryIn;
  logic [STAGES-1:0] stageValid;
  logic [STAGES-1:0] stageCarry;

  // Handshake: the pipe moves whenever the last slice is empty or being drained.
  always_comb begin
    adv      = !out_valid || out_ready;
    in_ready = adv && !rst;
    accept   = in_valid && in_ready;
    bEff     = sub ? ~b : b;
    c0       = sub ? 1'b1 : cin;
  end

  // Merge each slice's fresh chunk into the lower sum chunks carried alongside it.
  always_comb begin
    for (int i = 0; i < STAGES; i++) begin
      sumAsm[i] = sumLow_q[i];
      sumAsm[i][i*CHUNK +: CHUNK] = stageSum[i];
    end
  end

  // Route slice inputs: slice 0 sees the ports, later slices see the previous slice's registers.
  always_comb begin
    opA_d[0]        = a;
    opB_d[0]        = bEff;
    sumLow_d[0]     = '0;
    stageValidIn[0] = accept;
    stageCarryIn[0] = c0;
    for (int i = 1; i < STAGES; i++) begin
      opA_d[i]        = opA_q[i-1];
      opB_d[i]        = opB_q[i-1];
      sumLow_d[i]     = sumAsm[i-1];
      stageValidIn[i] = stageValid[i-1];
      stageCarryIn[i] = stageCarry[i-1];
    end
    for (int i = 0; i < STAGES; i++) begin
      aChunk[i] = opA_d[i][i*CHUNK +: CHUNK];
      bChunk[i] = opB_d[i][i*CHUNK +: CHUNK];
    end
  end

  // Skew registers advance in lockstep with the slices and clear on reset so s reads zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < STAGES; i++) begin
        opA_q[i]    <= '0;
        opB_q[i]    <= '0;
        sumLow_q[i] <= '0;
      end
    end else if (adv) begin
      for (int i = 0; i < STAGES; i++) begin
        opA_q[i]    <= opA_d[i];
        opB_q[i]    <= opB_d[i];
        sumLow_q[i] <= sumLow_d[i];
      end
    end
  end

  for (genvar gi = 0; gi < STAGES; gi++) begin : gStage
    pipe_adder_stage #(
      .CHUNK(CHUNK)
    ) uStage (
      .clk     (clk),
      .rst     (rst),
      .en_i    (adv),
      .valid_i (stageValidIn[gi]),
      .a_i     (aChunk[gi]),
      .b_i     (bChunk[gi]),
      .carry_i (stageCarryIn[gi]),
      .valid_o (stageValid[gi]),
      .sum_o   (stageSum[gi]),
      .carry_o (stageCarry[gi]),
      .ovf_o   (stageOvf[gi])
    );
  end

  assign out_valid = stageValid[STAGES-1];
  assign s         = sumAsm[STAGES-1];
  assign cout      = stageCarry[STAGES-1];
  assign ovf       = stageOvf[STAGES-1];

endmodule

// File: tb/tb_pipe_adder.sv
// tb_pipe_adder: directed vectors, backpressure, reset and a parameter sweep,
// all checked against an arithmetic reference model.
module tb_pipe_adder;

  localparam int W = 128;
  localparam int S = 8;
  localparam logic [127:0] ALL1 = {128{1'b1}};
  localparam logic [127:0] SMIN = {1'b1, {127{1'b0}}};
  localparam logic [127:0] SMAX = {1'b0, {127{1'b1}}};

  typedef struct {
    logic [127:0] a;
    logic [127:0] b;
    logic         cin;
    logic         sub;
    logic [127:0] s;
    logic         cout;
    logic         ovf;
  } vector_t;

  logic         clk = 1'b0;
  logic         rst;
  logic         inValid;
  logic         inReady;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         sub;
  logic         outValid;
  logic         outReady;
  logic [W-1:0] s;
  logic         cout;
  logic         ovf;

  int checks = 0;
  int errors = 0;
  int edgeCount = 0;
  int lastStallEdge = 0;
  int popCount = 0;
  int sweepDoneCount = 0;
  bit frontSeen = 1'b0;
  logic [129:0] expQ[$];
  int accEdgeQ[$];

  always #5 clk = ~clk;

  pipe_adder #(.WIDTH(W), .STAGES(S)) dut (
    .clk(clk), .rst(rst), .in_valid(inValid), .in_ready(inReady),
    .a(a), .b(b), .cin(cin), .sub(sub),
    .out_valid(outValid), .out_ready(outReady),
    .s(s), .cout(cout), .ovf(ovf)
  );

  task automatic checkOutput(input string name, input logic [129:0] act, input logic [129:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Expected {ovf, cout, s}: plain integer add or subtract, signed overflow from a wider signed result.
  function automatic logic [129:0] refMain(input logic [127:0] x, input logic [127:0] y, input logic c, input logic sb);
    logic [128:0] u;
    logic [129:0] sw;
    logic co;
    if (sb) begin
      u  = {1'b0, x} - {1'b0, y};
      co = (x >= y);
      sw = {{2{x[127]}}, x} - {{2{y[127]}}, y};
    end else begin
      u  = {1'b0, x} + {1'b0, y} + {128'b0, c};
      co = u[128];
      sw = {{2{x[127]}}, x} + {{2{y[127]}}, y} + {129'b0, c};
    end
    return {sw[128] ^ sw[127], co, u[127:0]};
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  always @(posedge clk) edgeCount++;

  // Scoreboard: every visible result must match the oldest accepted operand pair.
  always @(negedge clk) begin
    if (outValid) begin
      if (expQ.size() == 0) begin
        checkOutput("spuriousOutValid", 130'(outValid), 130'(0));
      end else begin
        checkOutput("monResult", {ovf, cout, s}, expQ[0]);
        if (!frontSeen) begin
          frontSeen = 1'b1;
          if (accEdgeQ[0] > lastStallEdge)
            checkOutput("monLatency", 130'(edgeCount - accEdgeQ[0] + 1), 130'(S));
        end
        if (outReady && !rst) begin
          void'(expQ.pop_front());
          void'(accEdgeQ.pop_front());
          frontSeen = 1'b0;
          popCount++;
        end
      end
      if (!outReady) lastStallEdge = edgeCount + 1;
    end
    if (rst) begin
      expQ.delete();
      accEdgeQ.delete();
      frontSeen = 1'b0;
      lastStallEdge = edgeCount + 1;
    end else if (inValid && inReady) begin
      expQ.push_back(refMain(a, b, cin, sub));
      accEdgeQ.push_back(edgeCount + 1);
    end
  end

  task automatic applyStimulus(input logic [127:0] opA, input logic [127:0] opB, input logic opCin, input logic opSub);
    int budget = 0;
    logic acc;
    a = opA; b = opB; cin = opCin; sub = opSub; inValid = 1'b1;
    do begin
      @(negedge clk);
      acc = inReady;
      @(posedge clk); #1;
      budget++;
    end while (!acc && budget < 200);
    if (!acc) checkOutput("acceptTimeout", 130'(acc), 130'(1));
    inValid = 1'b0;
  endtask

  task automatic waitResult(output int n);
    n = 1;
    while (!outValid && n < 4*S + 20) begin
      @(posedge clk); #1;
      n++;
    end
    checkOutput("resultArrives", 130'(outValid), 130'(1));
  endtask

  task automatic drainMain(input string name);
    int budget = 0;
    outReady = 1'b1;
    while (expQ.size() != 0 && budget < 200) begin
      @(posedge clk); #1;
      budget++;
    end
    checkOutput(name, 130'(expQ.size()), 130'(0));
  endtask

  initial begin
    vector_t vecs [10];
    int n;
    int cnt;
    int popsBefore;
    int budget;

    vecs[0] = '{128'd25, 128'd25, 1'b0, 1'b0, 128'd50, 1'b0, 1'b0};
    vecs[1] = '{ALL1, 128'd0, 1'b1, 1'b0, 128'd0, 1'b1, 1'b0};
    vecs[2] = '{SMAX, 128'd1, 1'b0, 1'b0, SMIN, 1'b0, 1'b1};
    vecs[3] = '{128'd5, 128'd7, 1'b0, 1'b1, ALL1 - 128'd1, 1'b0, 1'b0};
    vecs[4] = '{128'd7, 128'd5, 1'b0, 1'b1, 128'd2, 1'b1, 1'b0};
    vecs[5] = '{SMIN, 128'd1, 1'b0, 1'b1, SMAX, 1'b1, 1'b1};
    vecs[6] = '{128'd0, 128'd0, 1'b0, 1'b1, 128'd0, 1'b1, 1'b0};
    vecs[7] = '{128'd10, 128'd3, 1'b1, 1'b1, 128'd7, 1'b1, 1'b0};
    vecs[8] = '{128'h0000_FFFF, 128'd0, 1'b1, 1'b0, 128'h0001_0000, 1'b0, 1'b0};
    vecs[9] = '{ALL1, ALL1, 1'b1, 1'b0, ALL1, 1'b1, 1'b0};

    rst = 1'b1; inValid = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0; outReady = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("resetOutValid", 130'(outValid), 130'(0));
    checkOutput("resetS", 130'(s), 130'(0));
    checkOutput("resetCout", 130'(cout), 130'(0));
    checkOutput("resetOvf", 130'(ovf), 130'(0));
    checkOutput("readyLowInReset", 130'(inReady), 130'(0));
    rst = 1'b0;
    @(negedge clk);
    checkOutput("readyAfterReset", 130'(inReady), 130'(1));
    @(posedge clk); #1;

    for (int i = 0; i < 10; i++) begin
      applyStimulus(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].sub);
      waitResult(n);
      checkOutput($sformatf("vec%0d_latency", i), 130'(n), 130'(S));
      checkOutput($sformatf("vec%0d_s", i), 130'(s), 130'(vecs[i].s));
      checkOutput($sformatf("vec%0d_cout", i), 130'(cout), 130'(vecs[i].cout));
      checkOutput($sformatf("vec%0d_ovf", i), 130'(ovf), 130'(vecs[i].ovf));
      @(posedge clk); #1;
    end

    applyStimulus(128'd240, 128'd1232, 1'b0, 1'b0);
    applyStimulus(128'd32768, 128'd85070592, 1'b0, 1'b0);
    waitResult(n);
    checkOutput("b2bFirstLatency", 130'(n), 130'(S - 1));
    checkOutput("b2bFirstSum", 130'(s), 130'(1472));
    @(posedge clk); #1;
    checkOutput("b2bSecondValid", 130'(outValid), 130'(1));
    checkOutput("b2bSecondSum", 130'(s), 130'(85103360));
    @(posedge clk); #1;

    popsBefore = popCount;
    outReady = 1'b0;
    fork
      begin
        for (int i = 0; i < 20; i++)
          applyStimulus(rand128(), rand128(), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      end
      begin
        repeat (12) @(posedge clk);
        #1;
        checkOutput("bpPipeFull", 130'(outValid), 130'(1));
        checkOutput("bpReadyLow", 130'(inReady), 130'(0));
        outReady = 1'b1;
      end
    join
    drainMain("bpDrain");
    checkOutput("bpResultCount", 130'(popCount - popsBefore), 130'(20));

    for (int i = 0; i < 5; i++)
      applyStimulus(rand128(), rand128(), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    rst = 1'b1;
    @(negedge clk);
    checkOutput("midResetReadyLow", 130'(inReady), 130'(0));
    @(posedge clk); #1;
    rst = 1'b0;
    checkOutput("midResetOutValid", 130'(outValid), 130'(0));
    checkOutput("midResetS", 130'(s), 130'(0));
    checkOutput("midResetCout", 130'(cout), 130'(0));
    checkOutput("midResetOvf", 130'(ovf), 130'(0));
    @(negedge clk);
    checkOutput("midResetReadyBack", 130'(inReady), 130'(1));
    @(posedge clk); #1;
    cnt = 0;
    repeat (12) begin
      @(posedge clk); #1;
      if (outValid) cnt++;
    end
    checkOutput("noStaleResult", 130'(cnt), 130'(0));
    applyStimulus(128'd1, 128'd1, 1'b0, 1'b0);
    waitResult(n);
    checkOutput("freshLatency", 130'(n), 130'(S));
    checkOutput("freshSum", 130'(s), 130'(2));
    @(posedge clk); #1;

    a = 128'd9; b = 128'd9; cin = 1'b0; sub = 1'b0; inValid = 1'b1; rst = 1'b1;
    @(negedge clk);
    checkOutput("resetBeatsAcceptReady", 130'(inReady), 130'(0));
    @(posedge clk); #1;
    rst = 1'b0; inValid = 1'b0;
    cnt = 0;
    repeat (S + 4) begin
      @(posedge clk); #1;
      if (outValid) cnt++;
    end
    checkOutput("resetBeatsAccept", 130'(cnt), 130'(0));

    budget = 0;
    while (sweepDoneCount < 3 && budget < 5000) begin
      @(posedge clk); #1;
      budget++;
    end
    checkOutput("sweepFinished", 130'(sweepDoneCount), 130'(3));
    drainMain("finalDrain");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  for (genvar g = 0; g < 3; g++) begin : gSweep
    localparam int SW = (g == 0) ? 8 : ((g == 1) ? 32 : 64);
    localparam int SS = (g == 0) ? 1 : ((g == 1) ? 4 : 64);

    logic          swRst = 1'b1;
    logic          swInValid = 1'b0;
    logic          swInReady;
    logic          swCin = 1'b0;
    logic          swSub = 1'b0;
    logic          swOutValid;
    logic          swOutReady = 1'b1;
    logic          swCout;
    logic          swOvf;
    logic [SW-1:0] swA = '0;
    logic [SW-1:0] swB = '0;
    logic [SW-1:0] swS;
    logic [SW+1:0] swExpQ[$];
    int            swAccQ[$];
    int            swLastStall = 0;
    int            swLatChecks = 0;
    bit            swFrontSeen = 1'b0;

    pipe_adder #(.WIDTH(SW), .STAGES(SS)) dut (
      .clk(clk), .rst(swRst), .in_valid(swInValid), .in_ready(swInReady),
      .a(swA), .b(swB), .cin(swCin), .sub(swSub),
      .out_valid(swOutValid), .out_ready(swOutReady),
      .s(swS), .cout(swCout), .ovf(swOvf)
    );

    function automatic logic [SW+1:0] refSweep(input logic [SW-1:0] x, input logic [SW-1:0] y, input logic c, input logic sb);
      logic [SW:0]   u;
      logic [SW+1:0] sw;
      logic          co;
      if (sb) begin
        u  = {1'b0, x} - {1'b0, y};
        co = (x >= y);
        sw = {{2{x[SW-1]}}, x} - {{2{y[SW-1]}}, y};
      end else begin
        u  = {1'b0, x} + {1'b0, y} + {{SW{1'b0}}, c};
        co = u[SW];
        sw = {{2{x[SW-1]}}, x} + {{2{y[SW-1]}}, y} + {{(SW+1){1'b0}}, c};
      end
      return {sw[SW] ^ sw[SW-1], co, u[SW-1:0]};
    endfunction

    always @(negedge clk) begin
      if (swOutValid) begin
        if (swExpQ.size() == 0) begin
          checkOutput($sformatf("sweep%0d_spurious", SW), 130'(swOutValid), 130'(0));
        end else begin
          checkOutput($sformatf("sweep%0d_result", SW), 130'({swOvf, swCout, swS}), 130'(swExpQ[0]));
          if (!swFrontSeen) begin
            swFrontSeen = 1'b1;
            if (swAccQ[0] > swLastStall) begin
              checkOutput($sformatf("sweep%0d_latency", SW), 130'(edgeCount - swAccQ[0] + 1), 130'(SS));
              swLatChecks++;
            end
          end
          if (swOutReady && !swRst) begin
            void'(swExpQ.pop_front());
            void'(swAccQ.pop_front());
            swFrontSeen = 1'b0;
          end
        end
        if (!swOutReady) swLastStall = edgeCount + 1;
      end
      if (swRst) begin
        swExpQ.delete();
        swAccQ.delete();
        swFrontSeen = 1'b0;
        swLastStall = edgeCount + 1;
      end else if (swInValid && swInReady) begin
        swExpQ.push_back(refSweep(swA, swB, swCin, swSub));
        swAccQ.push_back(edgeCount + 1);
      end
    end

    initial begin
      int budget;
      repeat (2) @(posedge clk);
      #1;
      swRst = 1'b0;
      swA = SW'(3); swB = SW'(4); swInValid = 1'b1;
      @(posedge clk); #1;
      swInValid = 1'b0;
      repeat (SS + 3) @(posedge clk);
      #1;
      for (int i = 0; i < 300; i++) begin
        swInValid  = 1'($urandom_range(0, 1));
        swOutReady = ($urandom_range(0, 3) != 0);
        swA        = SW'({$urandom, $urandom});
        swB        = SW'({$urandom, $urandom});
        swCin      = 1'($urandom_range(0, 1));
        swSub      = 1'($urandom_range(0, 1));
        @(posedge clk); #1;
      end
      swInValid  = 1'b0;
      swOutReady = 1'b1;
      budget = 0;
      while (swExpQ.size() != 0 && budget < SS + 50) begin
        @(posedge clk); #1;
        budget++;
      end
      checkOutput($sformatf("sweep%0d_drain", SW), 130'(swExpQ.size()), 130'(0));
      checkOutput($sformatf("sweep%0d_latencySeen", SW), 130'(swLatChecks > 0), 130'(1));
      sweepDoneCount++;
    end
  end

endmodule
